// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct encodings and muldiv FSM types
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } md_state_e;

    // Single-cycle operations captured at start and retired on the following edge
    typedef enum logic [2:0] {
        PD_NONE,
        PD_MTHI,
        PD_MTLO,
        PD_MFHI,
        PD_MFLO,
        PD_DZ,
        PD_ILL,
        PD_FMUL
    } md_pend_e;

    function automatic logic is_signed_op(input logic [5:0] funct);
        return (funct == F_MULT) || (funct == F_DIV);
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// rtl/muldiv_divider.sv - restoring unsigned divider core, one quotient bit per step
module muldiv_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  last
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH:0]   shifted;
    logic                  fits;
    logic [DATA_WIDTH-1:0] diff;

    // Partial remainder shifted left with the next dividend bit; it is always below
    // 2*divisor, so the difference fits in DATA_WIDTH bits whenever it is taken.
    assign shifted = {rem_q, quo_q[DATA_WIDTH-1]};
    assign fits    = shifted >= {1'b0, dvs_q};
    assign diff    = shifted[DATA_WIDTH-1:0] - dvs_q;

    // Load operands or perform one restoring iteration
    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (load) begin
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
            cnt_d = CW'(DATA_WIDTH);
        end else if (step) begin
            rem_d = fits ? diff : shifted[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], fits};
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Divider state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == CW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - MIPS HI/LO multiply/divide unit; MULDIV_FAST_MUL_EN selects single-cycle multiply
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           instruction,
    input  logic [DATA_WIDTH-1:0] regA,
    input  logic [DATA_WIDTH-1:0] regB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  div_by_zero,
    output logic                  illegal
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    md_state_e       state_q, state_d;
    md_pend_e        pend_q, pend_d;
    logic [W-1:0]    pend_data_q, pend_data_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic            neg_p_q, neg_p_d, neg_r_q, neg_r_d, is_div_q, is_div_d;
    logic            busy_q, busy_d, done_q, done_d, dz_q, dz_d, ill_q, ill_d;

    logic [5:0]      funct;
    logic            opc_ok, sgn, a_neg, b_neg;
    logic [W-1:0]    mag_a, mag_b;
    logic            unused_instr;

    logic            div_load, div_step, div_last;
    logic [W-1:0]    div_quo, div_rem;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0]  fast_prod;
    assign fast_prod = {{W{1'b0}}, mcand_q} * {{W{1'b0}}, pend_data_q};
`else
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic [W:0]      mul_sum;
    // Shift-add: low half holds the remaining multiplier bits, high half accumulates
    assign mul_sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
`endif

    assign funct        = instruction[5:0];
    assign opc_ok       = (instruction[31:26] == OP_SPECIAL);
    assign unused_instr = ^instruction[25:6];
    assign sgn          = is_signed_op(funct);
    assign a_neg        = sgn & regA[W-1];
    assign b_neg        = sgn & regB[W-1];
    assign mag_a        = a_neg ? -regA : regA;
    assign mag_b        = b_neg ? -regB : regB;

    muldiv_divider #(.DATA_WIDTH(W)) u_divider (
        .clock     (clock),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    // Next-state: retire captured single-cycle ops, then advance the FSM
    always_comb begin
        state_d     = state_q;
        pend_d      = PD_NONE;
        pend_data_d = pend_data_q;
        mcand_d     = mcand_q;
        neg_p_d     = neg_p_q;
        neg_r_d     = neg_r_q;
        is_div_d    = is_div_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dz_d        = 1'b0;
        ill_d       = 1'b0;
        div_load    = 1'b0;
        div_step    = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
`else
        cnt_d       = cnt_q;
        prod_d      = prod_q;
`endif

        case (pend_q)
            PD_MTHI: begin hi_d = pend_data_q; done_d = 1'b1; end
            PD_MTLO: begin lo_d = pend_data_q; done_d = 1'b1; end
            PD_MFHI: begin result_d = hi_q; done_d = 1'b1; end
            PD_MFLO: begin result_d = lo_q; done_d = 1'b1; end
            PD_DZ:   begin dz_d = 1'b1; done_d = 1'b1; end
            PD_ILL:  begin ill_d = 1'b1; done_d = 1'b1; end
`ifdef MULDIV_FAST_MUL_EN
            PD_FMUL: begin
                {hi_d, lo_d} = neg_p_q ? -fast_prod : fast_prod;
                done_d = 1'b1;
            end
`endif
            default: ;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!opc_ok) begin
                        pend_d = PD_ILL;
                    end else begin
                        case (funct)
                            F_MTHI: begin pend_d = PD_MTHI; pend_data_d = regA; end
                            F_MTLO: begin pend_d = PD_MTLO; pend_data_d = regA; end
                            F_MFHI: pend_d = PD_MFHI;
                            F_MFLO: pend_d = PD_MFLO;
                            F_MULT, F_MULTU: begin
                                mcand_d  = mag_a;
                                neg_p_d  = a_neg ^ b_neg;
                                is_div_d = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
                                pend_d      = PD_FMUL;
                                pend_data_d = mag_b;
`else
                                prod_d  = {{W{1'b0}}, mag_b};
                                cnt_d   = CW'(W);
                                state_d = ST_MUL;
                                busy_d  = 1'b1;
`endif
                            end
                            F_DIV, F_DIVU: begin
                                if (regB == '0) begin
                                    pend_d = PD_DZ;
                                end else begin
                                    div_load = 1'b1;
                                    neg_p_d  = a_neg ^ b_neg;
                                    neg_r_d  = a_neg;
                                    is_div_d = 1'b1;
                                    state_d  = ST_DIV;
                                    busy_d   = 1'b1;
                                end
                            end
                            default: pend_d = PD_ILL;
                        endcase
                    end
                end
            end
`ifdef MULDIV_FAST_MUL_EN
`else
            ST_MUL: begin
                prod_d = {mul_sum, prod_q[W-1:1]};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_FIX;
            end
`endif
            ST_DIV: begin
                div_step = 1'b1;
                if (div_last) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    lo_d = neg_p_q ? -div_quo : div_quo;
                    hi_d = neg_r_q ? -div_rem : div_rem;
                end
`ifdef MULDIV_FAST_MUL_EN
`else
                else begin
                    {hi_d, lo_d} = neg_p_q ? -prod_q : prod_q;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pend_q      <= PD_NONE;
            pend_data_q <= '0;
            mcand_q     <= '0;
            neg_p_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            is_div_q    <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
            ill_q       <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
`else
            cnt_q       <= '0;
            prod_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            mcand_q     <= mcand_d;
            neg_p_q     <= neg_p_d;
            neg_r_q     <= neg_r_d;
            is_div_q    <= is_div_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dz_q        <= dz_d;
            ill_q       <= ill_d;
`ifdef MULDIV_FAST_MUL_EN
`else
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dz_q;
    assign illegal     = ill_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (table vectors, corner sequences, random vs model)
module tb_muldiv_unit;

    localparam int W  = 32;
    localparam int ML = 33;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    logic          clock = 1'b0;
    logic          reset, start;
    logic [31:0]   instruction;
    logic [W-1:0]  regA, regB;
    logic          busy, done, div_by_zero, illegal;
    logic [W-1:0]  result, hi, lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .instruction (instruction),
        .regA        (regA),
        .regB        (regB),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a, b;
        logic [31:0] ehi, elo, eres;
        logic        edz, eill;
        int          elat;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ehi, input logic [31:0] elo,
                                input logic [31:0] eres, input logic edz,
                                input logic eill, input int elat);
        vec_t v;
        v.op = op; v.fn = fn; v.a = a; v.b = b;
        v.ehi = ehi; v.elo = elo; v.eres = eres;
        v.edz = edz; v.eill = eill; v.elat = elat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits for done, returning the number of edges taken (100 if it never came)
    task automatic wait_done(output int n);
        n = 100;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    // Issues one op, scrambles the inputs after the start edge, and reports timing/flags
    task automatic run_op(input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cycles,
                          output logic dz, output logic ill, output logic lingering);
        instruction = {op, 20'h0, fn};
        regA  = a;
        regB  = b;
        start = 1'b1;
        tick();
        start       = 1'b0;
        instruction = $urandom;
        regA        = $urandom;
        regB        = $urandom;
        busy_cycles = busy ? 1 : 0;
        lat = 100;
        dz  = 1'b0;
        ill = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (busy) busy_cycles++;
            if (done) begin
                lat = i;
                dz  = div_by_zero;
                ill = illegal;
                break;
            end
        end
        tick();
        lingering = done | div_by_zero | illegal;
    endtask

    // Reference behaviour from the architectural definition of each instruction
    task automatic model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] mh, inout logic [31:0] ml, output logic dz);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        dz = 1'b0;
        sa = a;
        sb = b;
        case (fn)
            FN_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {mh, ml} = sp;
            end
            FN_MULTU: begin
                up = {32'h0, a} * {32'h0, b};
                {mh, ml} = up;
            end
            FN_DIV: begin
                if (sb == 0) dz = 1'b1;
                else if (a == 32'h8000_0000 && sb == -1) begin
                    ml = a;
                    mh = 32'h0;
                end else begin
                    ml = sa / sb;
                    mh = sa % sb;
                end
            end
            default: begin
                if (b == 0) dz = 1'b1;
                else begin
                    ml = a / b;
                    mh = a % b;
                end
            end
        endcase
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat, bc, n;
        logic        dz, ill, ling, seen;
        logic [31:0] mh, ml;
        logic        mdz;
        logic [5:0]  fn;
        logic [31:0] a, b;

        vecs[0]  = mk(6'h00, FN_MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 32'h0, 0, 0, ML);
        vecs[1]  = mk(6'h00, FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h0, 0, 0, ML);
        vecs[2]  = mk(6'h00, FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32'h0, 0, 0, ML);
        vecs[3]  = mk(6'h00, FN_MULT,  32'h80000000, 32'h1,        32'hFFFFFFFF, 32'h80000000, 32'h0, 0, 0, ML);
        vecs[4]  = mk(6'h00, FN_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 0, 0, 33);
        vecs[5]  = mk(6'h00, FN_DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32'h0, 0, 0, 33);
        vecs[6]  = mk(6'h00, FN_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 32'h0, 0, 0, 33);
        vecs[7]  = mk(6'h00, FN_DIVU,  32'h7,        32'h2,        32'h00000001, 32'h00000003, 32'h0, 0, 0, 33);
        vecs[8]  = mk(6'h00, FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h0, 0, 0, 33);
        vecs[9]  = mk(6'h00, FN_DIV,   32'h5,        32'h0,        32'h00000000, 32'h80000000, 32'h0, 1, 0, 1);
        vecs[10] = mk(6'h00, FN_MTHI,  32'h1234,     32'h0,        32'h00001234, 32'h80000000, 32'h0, 0, 0, 1);
        vecs[11] = mk(6'h00, FN_MFHI,  32'h0,        32'h0,        32'h00001234, 32'h80000000, 32'h1234, 0, 0, 1);
        vecs[12] = mk(6'h00, FN_MTLO,  32'hA5A5A5A5, 32'h0,        32'h00001234, 32'hA5A5A5A5, 32'h1234, 0, 0, 1);
        vecs[13] = mk(6'h00, FN_MFLO,  32'h0,        32'h0,        32'h00001234, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 1);
        vecs[14] = mk(6'h00, 6'h3F,    32'h9,        32'h9,        32'h00001234, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 1, 1);
        vecs[15] = mk(6'h01, FN_MULT,  32'h2,        32'h3,        32'h00001234, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 1, 1);
        vecs[16] = mk(6'h00, FN_DIVU,  32'h9,        32'h0,        32'h00001234, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, 0, 1);
        vecs[17] = mk(6'h00, FN_DIVU,  32'hFFFFFFFF, 32'hA,        32'h00000005, 32'h19999999, 32'hA5A5A5A5, 0, 0, 33);

        reset = 1'b1;
        start = 1'b0;
        instruction = '0;
        regA = '0;
        regB = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_busy",   64'(busy), 64'h0);
        check("reset_done",   64'(done), 64'h0);
        check("reset_flags",  64'({div_by_zero, illegal}), 64'h0);
        check("reset_hilo",   {hi, lo}, 64'h0);
        check("reset_result", 64'(result), 64'h0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, lat, bc, dz, ill, ling);
            check($sformatf("vec%0d_hi", i),     64'(hi), 64'(vecs[i].ehi));
            check($sformatf("vec%0d_lo", i),     64'(lo), 64'(vecs[i].elo));
            check($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].eres));
            check($sformatf("vec%0d_dz", i),     64'(dz), 64'(vecs[i].edz));
            check($sformatf("vec%0d_ill", i),    64'(ill), 64'(vecs[i].eill));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].elat));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].elat > 1 ? vecs[i].elat : 0));
            check($sformatf("vec%0d_pulse_width", i), 64'(ling), 64'h0);
        end

        // A MULT start issued while a DIV is in flight is dropped
        instruction = {6'h00, 20'h0, FN_DIV};
        regA = 32'd100;
        regB = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        instruction = {6'h00, 20'h0, FN_MULT};
        regA = 32'd3;
        regB = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("ignored_start_latency", 64'(n), 64'(33 - 4));
        check("ignored_start_hilo", {hi, lo}, {32'd2, 32'd14});

        // The next start is accepted in the done cycle of a MULT
        instruction = {6'h00, 20'h0, FN_MULT};
        regA = 32'd6;
        regB = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("b2b_mul_latency", 64'(n), 64'(ML));
        check("b2b_mul_hilo", {hi, lo}, {32'd0, 32'd42});
        instruction = {6'h00, 20'h0, FN_MTHI};
        regA = 32'hBEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_done_dropped", 64'(done), 64'h0);
        tick();
        check("b2b_mthi_done", 64'(done), 64'h1);
        check("b2b_mthi_hi", 64'(hi), 64'hBEEF);

        // Reset ten cycles into a DIV aborts it and clears HI/LO
        instruction = {6'h00, 20'h0, FN_DIV};
        regA = 32'd1000;
        regB = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("mid_div_busy", 64'(busy), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_hilo", {hi, lo}, 64'h0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen = seen | done;
        end
        check("abort_no_done", 64'(seen), 64'h0);

        // Reset wins over a simultaneous start
        instruction = {6'h00, 20'h0, FN_MTLO};
        regA = 32'h77;
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen = seen | done;
        end
        check("reset_over_start_done", 64'(seen), 64'h0);
        check("reset_over_start_lo", 64'(lo), 64'h0);

        // Random MULT/MULTU/DIV/DIVU against the reference model
        mh = 32'h0;
        ml = 32'h0;
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 3))
                0:       fn = FN_MULT;
                1:       fn = FN_MULTU;
                2:       fn = FN_DIV;
                default: fn = FN_DIVU;
            endcase
            a = pick();
            b = pick();
            model(fn, a, b, mh, ml, mdz);
            run_op(6'h00, fn, a, b, lat, bc, dz, ill, ling);
            check($sformatf("rnd%0d_fn%02h_a%08h_b%08h_hilo", k, fn, a, b), {hi, lo}, {mh, ml});
            check($sformatf("rnd%0d_dz", k), 64'(dz), 64'(mdz));
            check($sformatf("rnd%0d_latency", k), 64'(lat),
                  64'(mdz ? 1 : ((fn == FN_MULT || fn == FN_MULTU) ? ML : 33)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle MIPS multiply/divide unit. It sits beside the combinational `alu` in the execute stage. It takes the same `instruction`/`regA`/`regB` operand set and owns the architectural HI/LO registers, executing MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. Width is parametrised, multiply and divide are iterative (one bit per cycle), and the pipeline stalls on `busy` using a start/done handshake.

## Interface
- `DATA_WIDTH`, default 32: operand, HI, LO and result width; must be even and ≥ 4.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request; sampled only while `busy`=0.
- `instruction`  in  32: MIPS R-type word; opcode [31:26] must be 000000, funct is [5:0].
- `regA`  in  DATA_WIDTH: rs operand, dividend or multiplicand.
- `regB`  in  DATA_WIDTH: rt operand, divisor or multiplier.
- `busy`  out  1: operation in flight; further `start` is ignored.
- `done`  out  1: one-cycle completion pulse.
- `result`  out  DATA_WIDTH: MFHI/MFLO read data, registered and held until the next MFHI/MFLO.
- `hi`, `lo`  out  DATA_WIDTH: architectural HI/LO.
- `div_by_zero`  out  1: set with `done` on DIV/DIVU with `regB`=0.
- `illegal`  out  1: set with `done` on an unrecognised opcode/funct.

## Operation
- Funct codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- States: IDLE, MUL, DIV, FIX. FSM transitions:
  - IDLE→MUL on `start` with MULT/MULTU.
  - IDLE→DIV on `start` with DIV/DIVU when `regB`≠0.
  - MUL/DIV→FIX when the iteration counter reaches 0.
  - FIX→IDLE.
- Move ops, zero divisor and illegal encodings all complete from IDLE without leaving it.
- MTHI/MTLO: `hi`/`lo` ← `regA`. MFHI/MFLO: `result` ← `hi`/`lo`.
- Signed ops: magnitudes are latched at start, iterated unsigned, and sign-fixed in FIX.
  - Product sign is the XOR of the operand signs.
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
- Product is 2·DATA_WIDTH bits: HI gets the upper half, LO the lower half. Divide: LO = quotient, HI = remainder.
- Signed overflow: MIN / −1 gives LO=MIN, HI=0, with no flag.
- Divide by zero leaves HI/LO unchanged and raises `div_by_zero`.
- Illegal encodings leave all state unchanged and raise `illegal`.
- Operands are latched at start; later changes on `regA`/`regB`/`instruction` have no effect on the operation.

## Timing
- `start` sampled at edge E0.
- Move, div-by-zero and illegal ops: `done` (and the relevant flag) is high after E1. `busy` stays 0 throughout, and HI/LO/`result` update at E1.
- MUL/DIV:
  - `busy` is high after E0.
  - There are DATA_WIDTH iteration edges, then FIX.
  - HI/LO update and `done` rises at edge E(DATA_WIDTH+1); `busy` falls at the same edge.
  - The next `start` is accepted in the `done` cycle.
- `done`, `div_by_zero` and `illegal` are high for exactly one cycle.
- `start` while `busy`=1 is ignored: no queuing, no error.
- Reset values: `busy`, `done` and flags = 0; `hi`, `lo` and `result` = 0; state IDLE.
- Reset overrides `start`. Reset mid-operation aborts it, with no `done` and HI/LO cleared.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MULT/MULTU use a single-cycle full-width multiplier, with HI/LO and `done` at E1 and `busy` never asserted. MUL state is removed; DIV timing is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: iterative shift-add multiply with the timing above.

## Structure
- Shared package `mips_pkg`: opcode/funct localparams (shared with `alu`) and the FSM state encoding.
- One sub-module, `muldiv_divider`: restoring unsigned divider core taking magnitudes, with a load/step interface and its own counter.
- Sign handling and the multiplier stay in `muldiv_unit`.

## Test plan
All cases use DATA_WIDTH=32.
- MULT `regA`=FFFFFFFD (−3), `regB`=7 → `done` after E33; HI=FFFFFFFF, LO=FFFFFFEB.
- MULTU FFFFFFFF×FFFFFFFF → HI=FFFFFFFE, LO=00000001.
- DIV −7/2 → LO=FFFFFFFD, HI=FFFFFFFF. DIVU 7/2 → LO=3, HI=1. DIV 80000000/FFFFFFFF → LO=80000000, HI=0.
- DIV 5/0 → `div_by_zero` and `done` after E1, HI/LO unchanged, `busy` never high.
- MTHI 00001234 then MFHI → `result`=00001234 after E1. A MULT `start` issued while a DIV is busy is ignored; the DIV result is unchanged.
- `reset` asserted 10 cycles into a DIV → `busy`=0, HI=LO=0, no `done` pulse. A funct of 111111 → `illegal` pulse, all state unchanged.
